// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   ch_lsb()             : LSB of channel 'ch' in a packed N_CH*WIDTH data bus.
// Optional feature macro used by this block: MUX_LAST_LOCK_EN.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel i occupies [i*WIDTH +: WIDTH] of the packed input bus.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bus bundle for stream_mux_rr: N_CH producer streams in, one consumer stream out.
//   mode, sel            : source selection (fixed select or round-robin)
//   in_data/in_valid     : packed producer data and per-channel valid
//   in_ready             : per-channel ready back to producers
//   out_data/out_ch      : registered output beat and its source channel
//   out_valid/out_ready  : consumer handshake
//   in_last/out_last     : end-of-packet markers, only with MUX_LAST_LOCK_EN
// Modports: master = producer/consumer side, slave = the multiplexer.
//
// Handshake: a beat moves across a channel when valid and ready are both 1 at a
// rising clock edge. valid must not wait for ready; ready may be given without
// valid. The multiplexer holds out_valid/out_data/out_ch stable while out_valid=1
// and out_ready=0.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_LAST_LOCK_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_ch, out_valid, out_last
    );
    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_ch, out_valid, out_last
    );
`else
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
`endif

endinterface

// File: rtl/stream_mux_rr_rr_arbiter.sv
// rr_arbiter: combinational grant selection for stream_mux_rr.
//   req       : per-channel request vector
//   ptr       : first channel to consider; the scan wraps around
//   lock      : when 1, grant locked_ch regardless of req/ptr
//   locked_ch : channel held by an unfinished packet
//   grant     : one-hot grant, or zero when nothing is requested
//   grant_idx : encoded index of the granted channel (0 when grant is zero)
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock,
    input  logic [SEL_W-1:0] locked_ch,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (lock) begin
            grant[locked_ch] = 1'b1;
            grant_idx        = locked_ch;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                idx = (int'(ptr) + k) % N_CH;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = SEL_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH:1 stream multiplexer with a registered output stage.
// Sources are picked either by a fixed select (mode=0) or by round-robin
// arbitration over the valid channels (mode=1). Each output beat carries the
// index of the channel it came from.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : stream_mux_rr_if.slave (mode, sel, producer and consumer streams)
//   dbg_ptr   : current round-robin pointer
//   dbg_lock  : 1 while a multi-beat packet holds the grant
// Optional feature: define MUX_LAST_LOCK_EN to add in_last/out_last and keep the
// grant on one channel until that channel sends its last beat.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_rr_if.slave   bus,
    output logic [SEL_W-1:0] dbg_ptr,
    output logic             dbg_lock
);

    logic [SEL_W-1:0] ptr;
    logic             lock;
    logic [SEL_W-1:0] locked_ch;
    logic [N_CH-1:0]  sel_dec;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] next_ptr;
    logic [WIDTH-1:0] beat_data;
    logic             acc;
    logic             xfer;

    // Out-of-range sel decodes to no channel at all.
    always_comb begin
        sel_dec = '0;
        if (int'(bus.sel) < N_CH) begin
            sel_dec[bus.sel] = 1'b1;
        end
    end

    // In fixed mode the request is the one-hot select, so the arbiter returns
    // sel wherever ptr points and in_ready never depends on in_valid.
    assign req = (bus.mode == MODE_FIXED) ? sel_dec : bus.in_valid;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .lock      (lock),
        .locked_ch (locked_ch),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign acc          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = grant & {N_CH{acc}};
    assign xfer         = |(bus.in_valid & bus.in_ready);
    assign next_ptr     = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                beat_data = bus.in_data[ch_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

`ifdef MUX_LAST_LOCK_EN
    logic beat_last;
    assign beat_last = bus.in_last[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_last  <= 1'b0;
            ptr           <= '0;
            lock          <= 1'b0;
            locked_ch     <= '0;
        end else if (acc) begin
            if (xfer) begin
                bus.out_data  <= beat_data;
                bus.out_ch    <= grant_idx;
                bus.out_valid <= 1'b1;
                bus.out_last  <= beat_last;
                lock          <= ~beat_last;
                locked_ch     <= grant_idx;
                // The pointer moves on only once the packet is complete.
                if (beat_last) begin
                    ptr <= next_ptr;
                end
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
`else
    assign lock      = 1'b0;
    assign locked_ch = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (acc) begin
            if (xfer) begin
                bus.out_data  <= beat_data;
                bus.out_ch    <= grant_idx;
                bus.out_valid <= 1'b1;
                ptr           <= next_ptr;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
`endif

    assign dbg_ptr  = ptr;
    assign dbg_lock = lock;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr with N_CH=4, WIDTH=8.
module tb_stream_mux_rr;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
    logic [1:0] dbg_ptr;
    logic       dbg_lock;

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_ptr  (dbg_ptr),
        .dbg_lock (dbg_lock)
    );

    // ---------------- model / scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    bit          m_ov;
    logic [1:0]  m_ptr;
    bit          m_lock;
    logic [1:0]  m_lock_ch;
    logic [10:0] exp_q[$];   // {last, ch, data}

    typedef struct {
        bit         mode;
        logic [1:0] sel;
        logic [3:0] valid;
        bit         ordy;
        logic [3:0] exp_rdy;
    } vec_t;
    vec_t tab[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_grant(input bit m, input logic [1:0] s, input logic [3:0] v);
        int idx;
        if (m_lock) return 4'b0001 << m_lock_ch;
        if (!m) return 4'b0001 << s;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(m_ptr) + k) % 4;
            if (v[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    // ---------------- driver ----------------
    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic drive(input bit m, input logic [1:0] s, input logic [3:0] v,
                         input logic [3:0] last, input bit ordy, input logic [7:0] base,
                         input bit use_tab, input logic [3:0] tab_rdy);
        logic [3:0] g;
        logic [3:0] exp_rdy;
        bit         acc;
        int         idx;
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        for (int c = 0; c < 4; c++) bus.in_data[c*8 +: 8] = base + 8'(c);
`ifdef MUX_LAST_LOCK_EN
        bus.in_last = last;
`endif
        acc     = !m_ov || ordy;
        g       = model_grant(m, s, v);
        exp_rdy = acc ? g : 4'b0000;
        #2;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (use_tab) check("tab_in_ready", 32'(bus.in_ready), 32'(tab_rdy));
        if (m_ov && ordy && exp_q.size() != 0) void'(exp_q.pop_front());
        idx = -1;
        for (int c = 0; c < 4; c++) if (g[c]) idx = c;
        if (acc && idx >= 0 && v[idx]) begin
            exp_q.push_back({last[idx], 2'(idx), base + 8'(idx)});
`ifdef MUX_LAST_LOCK_EN
            if (last[idx]) begin
                m_lock = 1'b0;
                m_ptr  = 2'(idx + 1);
            end else begin
                m_lock    = 1'b1;
                m_lock_ch = 2'(idx);
            end
`else
            m_ptr = 2'(idx + 1);
`endif
        end
        if (acc) m_ov = (idx >= 0) && v[idx];
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("ptr", 32'(dbg_ptr), 32'(m_ptr));
        check("lock", 32'(dbg_lock), 32'(m_lock));
        if (m_ov && exp_q.size() != 0) begin
            check("out_beat", 32'({bus.out_ch, bus.out_data}), 32'(exp_q[0][9:0]));
`ifdef MUX_LAST_LOCK_EN
            check("out_last", 32'(bus.out_last), 32'(exp_q[0][10]));
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_ov      = 1'b0;
        m_ptr     = 2'd0;
        m_lock    = 1'b0;
        m_lock_ch = 2'd0;
        exp_q.delete();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_ch", 32'(bus.out_ch), 0);
        check("rst_ptr", 32'(dbg_ptr), 0);
`ifdef MUX_LAST_LOCK_EN
        check("rst_out_last", 32'(bus.out_last), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        tab[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
        tab[1]  = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
        tab[2]  = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
        tab[3]  = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
        tab[4]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010};
        tab[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
        tab[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
        tab[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
        tab[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
        tab[9]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
        tab[10] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100};
        tab[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
        tab[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
        tab[13] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b1000};
        tab[14] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001};
        tab[15] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001};

        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
`ifdef MUX_LAST_LOCK_EN
        bus.in_last   = '0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Table vectors; channel c data is 8'hA0 + 16*v + c.
        for (int v = 0; v < 16; v++) begin
            drive(tab[v].mode, tab[v].sel, tab[v].valid, 4'hF, tab[v].ordy,
                  8'hA0 + 8'(v * 16), 1'b1, tab[v].exp_rdy);
            if (v == 0) begin
                check("sel2_data", 32'(bus.out_data), 32'h A2);
                check("sel2_ch", 32'(bus.out_ch), 2);
            end
            if (v >= 1 && v <= 3) check("bp_hold_data", 32'(bus.out_data), 32'h A2);
        end

        // Fairness: all valid, consumer always ready.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 4'hF, 4'hF, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 4'h0);
            check("rr_order", 32'(bus.out_ch), 32'(i % 4));
        end

        // Sparse valids 1010 from ptr=0, then everything idle.
        do_reset();
        drive(1'b1, 2'd0, 4'b1010, 4'hF, 1'b1, 8'h10, 1'b0, 4'h0);
        check("alt_ch0", 32'(bus.out_ch), 1);
        drive(1'b1, 2'd0, 4'b1010, 4'hF, 1'b1, 8'h20, 1'b0, 4'h0);
        check("alt_ch1", 32'(bus.out_ch), 3);
        drive(1'b1, 2'd0, 4'b1010, 4'hF, 1'b1, 8'h30, 1'b0, 4'h0);
        check("alt_ch2", 32'(bus.out_ch), 1);
        drive(1'b1, 2'd0, 4'b0000, 4'hF, 1'b1, 8'h40, 1'b0, 4'h0);
        check("idle_valid_drop", 32'(bus.out_valid), 0);
        check("idle_ptr_hold", 32'(dbg_ptr), 2);
        drive(1'b1, 2'd0, 4'b0000, 4'hF, 1'b1, 8'h50, 1'b0, 4'h0);
        check("idle_ptr_hold2", 32'(dbg_ptr), 2);

        // Reset while a beat is stalled at the output.
        drive(1'b0, 2'd3, 4'hF, 4'hF, 1'b0, 8'h60, 1'b0, 4'h0);
        check("pre_rst_ch", 32'(bus.out_ch), 3);
        bus.out_ready = 1'b0;
        do_reset();
        drive(1'b1, 2'd3, 4'hF, 4'hF, 1'b1, 8'h70, 1'b0, 4'h0);
        check("post_rst_rr_ch", 32'(bus.out_ch), 0);

`ifdef MUX_LAST_LOCK_EN
        // Three-beat packet on channel 0; sel/mode changes must not break it.
        do_reset();
        drive(1'b1, 2'd0, 4'hF, 4'b0000, 1'b1, 8'h80, 1'b0, 4'h0);
        check("pkt_beat0", 32'(bus.out_ch), 0);
        drive(1'b0, 2'd3, 4'hF, 4'b0000, 1'b1, 8'h90, 1'b0, 4'h0);
        check("pkt_beat1", 32'(bus.out_ch), 0);
        drive(1'b0, 2'd2, 4'hF, 4'b0001, 1'b1, 8'hB0, 1'b0, 4'h0);
        check("pkt_beat2", 32'(bus.out_ch), 0);
        check("pkt_last", 32'(bus.out_last), 1);
        drive(1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 8'hC0, 1'b0, 4'h0);
        check("pkt_next_ch", 32'(bus.out_ch), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
